// File: rtl/ace_rd_arbiter_if.sv
`timescale 1ns/1ps
// ACE read channel bundle (AR + R + RACK); the master side drives AR/RREADY/RACK.
// Payloads are packed AR {id, addr, len, size, burst, snoop, domain} and R {id, data, resp, last}.
interface ace_rd_arbiter_if #(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32
);
    localparam int ACE_XID_WIDTH     = 6;
    localparam int ACE_AXLEN_WIDTH   = 8;
    localparam int ACE_AXSIZE_WIDTH  = 3;
    localparam int ACE_AXBURST_WIDTH = 2;
    localparam int ACE_ARSNOOP_WIDTH = 4;
    localparam int ACE_DOMAIN_WIDTH  = 2;
    localparam int ACE_RRESP_WIDTH   = 4;
    localparam int AR_W = ACE_XID_WIDTH + ACE_AXADDR_WIDTH + ACE_AXLEN_WIDTH + ACE_AXSIZE_WIDTH
                        + ACE_AXBURST_WIDTH + ACE_ARSNOOP_WIDTH + ACE_DOMAIN_WIDTH;
    localparam int R_W  = ACE_XID_WIDTH + ACE_XDATA_WIDTH + ACE_RRESP_WIDTH + 1;

    logic [AR_W-1:0] ar_payload;
    logic            arvalid;
    logic            arready;
    logic [R_W-1:0]  r_payload;
    logic            rvalid;
    logic            rready;
    logic            rack;

    modport master (output ar_payload, arvalid, rready, rack,
                    input  arready, r_payload, rvalid);
    modport slave  (input  ar_payload, arvalid, rready,
                    output arready, r_payload, rvalid);
endinterface

// File: rtl/ace_rd_arbiter.sv
`timescale 1ns/1ps
// Two-requester ACE read arbiter (s0 = IFU, s1 = LSU) sharing one manager AR/R/RACK port.
// Define ACE_RD_ARB_FIXED_PRIO_EN to make s1 win every tie instead of round-robin.
module ace_rd_arbiter #(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic clk,
    input  logic rst,
    ace_rd_arbiter_if.slave  s0,
    ace_rd_arbiter_if.slave  s1,
    ace_rd_arbiter_if.master m
);
    // Field widths must match ace_rd_arbiter_if.
    localparam int ACE_XID_WIDTH = 6;
    localparam int AR_W  = ACE_XID_WIDTH + ACE_AXADDR_WIDTH + 8 + 3 + 2 + 4 + 2;
    localparam int R_W   = ACE_XID_WIDTH + ACE_XDATA_WIDTH + 4 + 1;
    localparam int AR_LO = AR_W - ACE_XID_WIDTH;
    localparam int R_LO  = R_W - ACE_XID_WIDTH;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      s_arvalid;
    logic [1:0]      elig;
    logic [1:0]      ar_hs;
    logic            tie_pick;
    logic            m_arvalid_next;
    logic [AR_W-1:0] m_ar_payload_next;
    logic            s0_arready_next, s1_arready_next;
    logic [AR_W-1:0] s0_tagged, s1_tagged;
    logic            r_tag, r_done;
    logic            m_rack_reg;
    logic            unused_id_msb;

    assign s_arvalid = {s1.arvalid, s0.arvalid};
    assign ar_hs     = {(state_reg == HOLD1) && m.arready, (state_reg == HOLD0) && m.arready};

    // Source index replaces the requester's (always zero) id MSB at the LSB end.
    assign s0_tagged = {s0.ar_payload[AR_W-2 -: ACE_XID_WIDTH-1], 1'b0, s0.ar_payload[AR_LO-1:0]};
    assign s1_tagged = {s1.ar_payload[AR_W-2 -: ACE_XID_WIDTH-1], 1'b1, s1.ar_payload[AR_LO-1:0]};
    assign unused_id_msb = s0.ar_payload[AR_W-1] ^ s1.ar_payload[AR_W-1];

`ifdef ACE_RD_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b1;
`else
    logic rr_last_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_reg <= 1'b1;
        end else if (ar_hs[1]) begin
            rr_last_reg <= 1'b1;
        end else if (ar_hs[0]) begin
            rr_last_reg <= 1'b0;
        end
    end

    assign tie_pick = ~rr_last_reg;
`endif

    always_comb begin
        state_next        = state_reg;
        m_arvalid_next    = 1'b0;
        m_ar_payload_next = '0;
        s0_arready_next   = 1'b0;
        s1_arready_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (elig == 2'b11) begin
                    state_next = tie_pick ? HOLD1 : HOLD0;
                end else if (elig[0]) begin
                    state_next = HOLD0;
                end else if (elig[1]) begin
                    state_next = HOLD1;
                end
            end
            HOLD0: begin
                m_arvalid_next    = 1'b1;
                m_ar_payload_next = s0_tagged;
                s0_arready_next   = m.arready;
                if (m.arready) begin
                    state_next = IDLE;
                end
            end
            HOLD1: begin
                m_arvalid_next    = 1'b1;
                m_ar_payload_next = s1_tagged;
                s1_arready_next   = m.arready;
                if (m.arready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign m.arvalid    = m_arvalid_next;
    assign m.ar_payload = m_ar_payload_next;
    assign s0.arready   = s0_arready_next;
    assign s1.arready   = s1_arready_next;

    // R path is pure routing on id[0]; the original id is shifted back into place.
    assign r_tag        = m.r_payload[R_LO];
    assign s0.r_payload = {1'b0, m.r_payload[R_W-1 -: ACE_XID_WIDTH-1], m.r_payload[R_LO-1:0]};
    assign s1.r_payload = {1'b0, m.r_payload[R_W-1 -: ACE_XID_WIDTH-1], m.r_payload[R_LO-1:0]};
    assign s0.rvalid    = m.rvalid & ~r_tag;
    assign s1.rvalid    = m.rvalid & r_tag;
    assign m.rready     = r_tag ? s1.rready : s0.rready;
    assign r_done       = m.rvalid && m.rready && m.r_payload[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic             inc, dec;

        assign inc      = ar_hs[gi];
        // A last beat for a requester with nothing outstanding is forwarded but not counted.
        assign dec      = r_done && (r_tag == 1'(gi)) && (cnt_reg != '0);
        assign elig[gi] = s_arvalid[gi] && (cnt_reg < CNT_W'(MAX_OUTSTANDING));

        always_comb begin
            cnt_next = cnt_reg;
            if (inc && !dec) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

`ifndef SYNTHESIS
        assert property (@(posedge clk) disable iff (!rst)
            !(m.rvalid && m.rready && (r_tag == 1'(gi)) && (cnt_reg == '0)));
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rack_reg <= 1'b0;
        end else begin
            m_rack_reg <= r_done;
        end
    end

    assign m.rack = m_rack_reg;
endmodule

// File: tb/tb_ace_rd_arbiter.sv
`timescale 1ns/1ps
// Directed plus randomized bench for ace_rd_arbiter against a transaction-level model.
module tb_ace_rd_arbiter;
    localparam int XD   = 256;
    localparam int AW   = 32;
    localparam int MAXO = 4;
    localparam int XID  = 6;
    localparam int AR_W = XID + AW + 8 + 3 + 2 + 4 + 2;
    localparam int R_W  = XID + XD + 4 + 1;

    typedef struct {
        logic [XID-1:0] id;
        int             len;
    } rtxn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ace_rd_arbiter_if #(.ACE_XDATA_WIDTH(XD), .ACE_AXADDR_WIDTH(AW)) s0_if ();
    ace_rd_arbiter_if #(.ACE_XDATA_WIDTH(XD), .ACE_AXADDR_WIDTH(AW)) s1_if ();
    ace_rd_arbiter_if #(.ACE_XDATA_WIDTH(XD), .ACE_AXADDR_WIDTH(AW)) m_if ();

    ace_rd_arbiter #(.ACE_XDATA_WIDTH(XD), .ACE_AXADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk),
        .rst(rst),
        .s0 (s0_if),
        .s1 (s1_if),
        .m  (m_if)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus controls: s_mode 0 = quiet, 1 = always requesting, 2 = random.
    int              s_mode [2];
    logic            s_pend [2];
    logic [AR_W-1:0] s_pay  [2];
    bit              ar_rand, rr_rand, r_en;
    int              len_max;

    // Interconnect: in-order R return of accepted ARs.
    rtxn_t          q[$];
    logic           r_active;
    logic [R_W-1:0] r_pay;
    int             bcnt;

    // Reference model: who owns the AR slot, per-source in-flight counts, last winner.
    int   hold_m;
    int   cnt_m [2];
    int   rr_m;
    logic rack_m;

    int              dut_grant;
    logic            dut_arvalid;
    logic [AR_W-1:0] dut_ar_pay;

    task automatic chk(input string name, input logic [R_W-1:0] obs, input logic [R_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [R_W-1:0] rand_wide();
        logic [R_W-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v = (v << 32) | R_W'($urandom());
        return v;
    endfunction

    function automatic logic [AR_W-1:0] mk_ar(input int id, input logic [31:0] addr, input int len);
        return {XID'(id), addr, 8'(len), 3'd5, 2'd1, 4'($urandom()), 2'($urandom())};
    endfunction

    function automatic logic [AR_W-1:0] tagged_ar(input logic [AR_W-1:0] p, input int n);
        logic [AR_W-1:0] r;
        int              id;
        id = int'(p[AR_W-1 -: XID]);
        r  = p;
        r[AR_W-1 -: XID] = XID'((id * 2 + n) % 64);
        return r;
    endfunction

    task automatic cycle();
        int             tag, rid, aid, alen;
        logic           exp_rready, ar_hs, r_hs, r_last;
        logic [R_W-1:0] exp_rp;
        for (int n = 0; n < 2; n++) begin
            if (!s_pend[n] && (s_mode[n] == 1 || (s_mode[n] == 2 && $urandom_range(0, 2) == 0))) begin
                s_pend[n] = 1'b1;
                s_pay[n]  = mk_ar($urandom_range(0, 31), $urandom(), $urandom_range(0, len_max));
            end
        end
        s0_if.arvalid    = s_pend[0];
        s0_if.ar_payload = s_pay[0];
        s1_if.arvalid    = s_pend[1];
        s1_if.ar_payload = s_pay[1];
        if (ar_rand) m_if.arready = 1'($urandom_range(0, 1));
        if (rr_rand) begin
            s0_if.rready = 1'($urandom_range(0, 1));
            s1_if.rready = 1'($urandom_range(0, 1));
        end
        if (!r_active && r_en && q.size() > 0) begin
            r_active = 1'b1;
            r_pay    = rand_wide();
            r_pay[R_W-1 -: XID] = q[0].id;
            r_pay[0] = (bcnt == q[0].len);
        end
        m_if.rvalid    = r_active;
        m_if.r_payload = r_pay;
        #1;
        chk("m_arvalid", R_W'(m_if.arvalid), R_W'(hold_m >= 0));
        if (hold_m >= 0) chk("m_ar_payload", R_W'(m_if.ar_payload), R_W'(tagged_ar(s_pay[hold_m], hold_m)));
        chk("s0_arready", R_W'(s0_if.arready), R_W'(hold_m == 0 && m_if.arready));
        chk("s1_arready", R_W'(s1_if.arready), R_W'(hold_m == 1 && m_if.arready));
        rid = int'(r_pay[R_W-1 -: XID]);
        tag = rid % 2;
        chk("s0_rvalid", R_W'(s0_if.rvalid), R_W'(r_active && tag == 0));
        chk("s1_rvalid", R_W'(s1_if.rvalid), R_W'(r_active && tag == 1));
        exp_rready = (tag == 1) ? s1_if.rready : s0_if.rready;
        if (r_active) begin
            chk("m_rready", R_W'(m_if.rready), R_W'(exp_rready));
            exp_rp = r_pay;
            exp_rp[R_W-1 -: XID] = XID'(rid / 2);
            chk("s0_r_payload", s0_if.r_payload, exp_rp);
            chk("s1_r_payload", s1_if.r_payload, exp_rp);
        end
        chk("m_rack", R_W'(m_if.rack), R_W'(rack_m));
        dut_grant   = s0_if.arready ? 0 : (s1_if.arready ? 1 : -1);
        dut_arvalid = m_if.arvalid;
        dut_ar_pay  = m_if.ar_payload;
        ar_hs  = (hold_m >= 0) && m_if.arready;
        r_hs   = r_active && exp_rready;
        r_last = r_pay[0];
        @(posedge clk);
        if (ar_hs) begin
            aid  = int'(s_pay[hold_m][AR_W-1 -: XID]);
            alen = int'(s_pay[hold_m][AR_W-XID-AW-1 -: 8]);
            cnt_m[hold_m]++;
            rr_m = hold_m;
            q.push_back('{id: XID'(aid * 2 + hold_m), len: alen});
            s_pend[hold_m] = 1'b0;
            $display("AR  src=%0d id=%0h len=%0d cnt=%0d", hold_m, aid, alen, cnt_m[hold_m]);
            hold_m = -1;
        end else if (hold_m < 0) begin
            if (s_pend[0] && cnt_m[0] < MAXO && s_pend[1] && cnt_m[1] < MAXO) begin
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
                hold_m = 1;
`else
                hold_m = 1 - rr_m;
`endif
            end else if (s_pend[0] && cnt_m[0] < MAXO) begin
                hold_m = 0;
            end else if (s_pend[1] && cnt_m[1] < MAXO) begin
                hold_m = 1;
            end
        end
        rack_m = r_hs && r_last;
        if (r_hs) begin
            r_active = 1'b0;
            if (r_last) begin
                if (cnt_m[tag] > 0) cnt_m[tag]--;
                void'(q.pop_front());
                bcnt = 0;
                $display("R   dst=%0d id=%0h done", tag, rid / 2);
            end else begin
                bcnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_m_arvalid", R_W'(m_if.arvalid), '0);
        chk("rst_m_ar_payload", R_W'(m_if.ar_payload), '0);
        chk("rst_s0_arready", R_W'(s0_if.arready), '0);
        chk("rst_s1_arready", R_W'(s1_if.arready), '0);
        chk("rst_m_rack", R_W'(m_if.rack), '0);
        hold_m = -1; cnt_m[0] = 0; cnt_m[1] = 0; rr_m = 1; rack_m = 1'b0;
        q.delete(); r_active = 1'b0; bcnt = 0;
        s_pend[0] = 1'b0; s_pend[1] = 1'b0; s_mode[0] = 0; s_mode[1] = 0;
        s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; m_if.rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        s_mode[0] = 0; s_mode[1] = 0;
        ar_rand = 1'b0; rr_rand = 1'b0; r_en = 1'b1;
        m_if.arready = 1'b1; s0_if.rready = 1'b1; s1_if.rready = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (q.size() == 0 && hold_m < 0 && !s_pend[0] && !s_pend[1] && !r_active) done = 1'b1;
            else cycle();
        end
        chk("drain_done", R_W'(done), R_W'(1));
    endtask

    initial begin
        int n0, n1, ngr, prev, exp_src;
        bit got;
        logic [AR_W-1:0] first_pay;
        s_mode[0] = 0; s_mode[1] = 0; s_pend[0] = 1'b0; s_pend[1] = 1'b0;
        s_pay[0] = '0; s_pay[1] = '0;
        ar_rand = 1'b0; rr_rand = 1'b0; r_en = 1'b0; len_max = 0;
        r_active = 1'b0; r_pay = '0; bcnt = 0;
        s0_if.arvalid = 1'b0; s0_if.ar_payload = '0; s0_if.rready = 1'b1;
        s1_if.arvalid = 1'b0; s1_if.ar_payload = '0; s1_if.rready = 1'b1;
        m_if.arready = 1'b1; m_if.rvalid = 1'b0; m_if.r_payload = '0;
        #2;
        do_reset();

        // Single IFU fetch: AR appears on the second cycle with id 0.
        s_pay[0]  = mk_ar(0, 32'h8000_0000, 0);
        s_pend[0] = 1'b1;
        cycle();
        chk("first_idle_arvalid", R_W'(dut_arvalid), '0);
        cycle();
        chk("first_hold_arvalid", R_W'(dut_arvalid), R_W'(1));
        chk("first_hold_id", R_W'(dut_ar_pay[AR_W-1 -: XID]), '0);
        chk("first_grant", R_W'(dut_grant), R_W'(0));
        cycle();
        chk("first_after_arready", R_W'(dut_grant), R_W'(-1));
        drain();

        // Both requesters always valid: grants alternate (or s1 always with fixed priority).
        s_mode[0] = 1; s_mode[1] = 1; len_max = 0; prev = 0; ngr = 0;
        for (int i = 0; i < 40 && ngr < 8; i++) begin
            cycle();
            if (dut_grant >= 0) begin
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
                exp_src = 1;
`else
                exp_src = 1 - prev;
`endif
                chk("alt_grant", R_W'(dut_grant), R_W'(exp_src));
                prev = dut_grant;
                ngr++;
            end
        end
        chk("alt_count", R_W'(ngr), R_W'(8));
        drain();

        // s1 fills its in-flight budget; s0 still gets through; one s1 completion frees s1.
        s_mode[1] = 1; r_en = 1'b0; n1 = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (dut_grant == 1) n1++;
        end
        chk("full_s1_grants", R_W'(n1), R_W'(MAXO));
        chk("full_stall_arvalid", R_W'(dut_arvalid), '0);
        s_mode[0] = 1; got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle();
            if (dut_grant == 0) begin got = 1'b1; s_mode[0] = 0; end
        end
        chk("full_s0_proceeds", R_W'(got), R_W'(1));
        r_en = 1'b1;
        for (int i = 0; i < 10 && cnt_m[1] == MAXO; i++) cycle();
        r_en = 1'b0; got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            cycle();
            if (dut_grant == 1) got = 1'b1;
        end
        chk("full_release", R_W'(got), R_W'(1));
        drain();

        // AR held in HOLD0 while the interconnect stalls: payload and grant stay put.
        m_if.arready = 1'b0; s_mode[0] = 1;
        cycle();
        s_mode[1] = 1;
        cycle();
        first_pay = dut_ar_pay;
        chk("stall_arvalid0", R_W'(dut_arvalid), R_W'(1));
        chk("stall_tag", R_W'(int'(dut_ar_pay[AR_W-1 -: XID]) % 2), '0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_payload", R_W'(dut_ar_pay), R_W'(first_pay));
            chk("stall_arvalid", R_W'(dut_arvalid), R_W'(1));
        end
        m_if.arready = 1'b1; s_mode[0] = 0;
        cycle();
        chk("stall_grant", R_W'(dut_grant), R_W'(0));
        drain();

        // Reset in the middle of HOLD1 with two s0 reads outstanding.
        r_en = 1'b0; s_mode[0] = 1; n0 = 0;
        for (int i = 0; i < 10 && n0 < 2; i++) begin
            cycle();
            if (dut_grant == 0) n0++;
            if (n0 == 2) s_mode[0] = 0;
        end
        chk("pre_rst_s0_grants", R_W'(n0), R_W'(2));
        s_mode[1] = 1; m_if.arready = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_hold1", R_W'(dut_arvalid && int'(dut_ar_pay[AR_W-1 -: XID]) % 2 == 1), R_W'(1));
        do_reset();
        s_mode[0] = 1; m_if.arready = 1'b1; n0 = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (dut_grant == 0) n0++;
        end
        chk("post_rst_s0_grants", R_W'(n0), R_W'(MAXO));
        drain();

        // Randomized traffic on both requesters and both channels.
        s_mode[0] = 2; s_mode[1] = 2; ar_rand = 1'b1; rr_rand = 1'b1; r_en = 1'b1; len_max = 3;
        repeat (600) cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
